// File: rtl/round_sequencer.sv
// Round sequencer: turns a level start request into one load strobe plus NUM_ROUNDS round enables.
// Optional stall input for the round phase is enabled by defining ROUND_STALL_EN.
module round_sequencer #(
    parameter int NUM_ROUNDS = 24,
    parameter int RND_W      = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             State_start,
`ifdef ROUND_STALL_EN
    input  logic             Stall,
`endif
    output logic             Load_en,
    output logic             Round_en,
    output logic [RND_W-1:0] Round_idx,
    output logic             Busy,
    output logic             Done_flag
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Comparison at RND_W width so NUM_ROUNDS = 2^RND_W ends on the all-ones index.
    localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NUM_ROUNDS - 1);

    logic [1:0]       r_state;
    logic [RND_W-1:0] r_cnt;
    logic             r_load;
    logic             r_round_en;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [RND_W-1:0] w_cnt_nxt;
    logic             w_hold;
    logic             w_stall;

`ifdef ROUND_STALL_EN
    assign w_stall = Stall;
`else
    assign w_stall = 1'b0;
`endif

    // Next-state and round-counter selection; abort outranks stall and completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = {RND_W{1'b0}};
                if (State_start) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_cnt_nxt = {RND_W{1'b0}};
                if (State_start) begin
                    w_state_nxt = S_ROUND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ROUND: begin
                if (!State_start) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {RND_W{1'b0}};
                end else if (w_stall) begin
                    w_state_nxt = S_ROUND;
                    w_hold      = 1'b1;
                end else if (r_cnt == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = {RND_W{1'b0}};
                end else begin
                    w_state_nxt = S_ROUND;
                    w_cnt_nxt   = r_cnt + RND_W'(1'b1);
                end
            end
            S_DONE: begin
                w_cnt_nxt = {RND_W{1'b0}};
                if (State_start) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {RND_W{1'b0}};
            end
        endcase
    end

    // State, counter and outputs are all registered from the next-state decode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= {RND_W{1'b0}};
            r_load     <= 1'b0;
            r_round_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_load     <= (w_state_nxt == S_LOAD);
            r_round_en <= (w_state_nxt == S_ROUND) && !w_hold;
            r_busy     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_ROUND);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign Load_en   = r_load;
    assign Round_en  = r_round_en;
    assign Round_idx = r_cnt;
    assign Busy      = r_busy;
    assign Done_flag = r_done;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: three instances (24, 32 and 1 rounds) checked against a phase-count model.
module tb_round_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic start_s = 1'b0;
    logic stall_s = 1'b0;

    logic ld_a, rn_a, by_a, dn_a; logic [4:0] ix_a;
    logic ld_b, rn_b, by_b, dn_b; logic [4:0] ix_b;
    logic ld_c, rn_c, by_c, dn_c; logic [4:0] ix_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: ph = -1 idle, 0 load, 1..N round (index ph-1), N+1 done; stl marks a held round.
    int ph [3];
    bit stl [3];
    int nr [3];

    always #5 CLK = ~CLK;

    round_sequencer #(.NUM_ROUNDS(24), .RND_W(5)) dut (
        .CLK(CLK), .RST(RST), .State_start(start_s),
`ifdef ROUND_STALL_EN
        .Stall(stall_s),
`endif
        .Load_en(ld_a), .Round_en(rn_a), .Round_idx(ix_a), .Busy(by_a), .Done_flag(dn_a));

    round_sequencer #(.NUM_ROUNDS(32), .RND_W(5)) dut32 (
        .CLK(CLK), .RST(RST), .State_start(start_s),
`ifdef ROUND_STALL_EN
        .Stall(stall_s),
`endif
        .Load_en(ld_b), .Round_en(rn_b), .Round_idx(ix_b), .Busy(by_b), .Done_flag(dn_b));

    round_sequencer #(.NUM_ROUNDS(1), .RND_W(5)) dut1 (
        .CLK(CLK), .RST(RST), .State_start(start_s),
`ifdef ROUND_STALL_EN
        .Stall(stall_s),
`endif
        .Load_en(ld_c), .Round_en(rn_c), .Round_idx(ix_c), .Busy(by_c), .Done_flag(dn_c));

    function automatic logic [8:0] obs(int i);
        case (i)
            0:       return {ld_a, rn_a, ix_a, by_a, dn_a};
            1:       return {ld_b, rn_b, ix_b, by_b, dn_b};
            default: return {ld_c, rn_c, ix_c, by_c, dn_c};
        endcase
    endfunction

    function automatic logic [8:0] expv(int i);
        logic [4:0] idx;
        if (ph[i] == 0) return {1'b1, 1'b0, 5'd0, 1'b1, 1'b0};
        if (ph[i] >= 1 && ph[i] <= nr[i]) begin
            idx = 5'(ph[i] - 1);
            return {1'b0, !stl[i], idx, 1'b1, 1'b0};
        end
        if (ph[i] == nr[i] + 1) return {1'b0, 1'b0, 5'd0, 1'b0, 1'b1};
        return 9'd0;
    endfunction

    function automatic void model_update();
        for (int i = 0; i < 3; i++) begin
            if (RST) begin
                ph[i] = -1; stl[i] = 1'b0;
            end else if (ph[i] == -1) begin
                if (start_s) ph[i] = 0;
            end else if (ph[i] == nr[i] + 1) begin
                if (!start_s) ph[i] = -1;
            end else if (!start_s) begin
                ph[i] = -1; stl[i] = 1'b0;
            end else if (ph[i] >= 1 && stall_s) begin
                stl[i] = 1'b1;
            end else begin
                ph[i] = ph[i] + 1; stl[i] = 1'b0;
            end
        end
    endfunction

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle_out(int n);
        start_s = 1'b0;
        stall_s = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        #1 RST = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            ph[i] = -1; stl[i] = 1'b0;
            n_checks++;
            if (obs(i) !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_async[%0d] got=%b exp=%b", i, obs(i), 9'd0);
            end
        end
        step(); step();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs(i) !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_held[%0d] got=%b exp=%b", i, obs(i), 9'd0);
            end
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        start_s = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL nominal[%0d] cyc=%0d got=%b exp=%b", i, c, obs(i), expv(i));
                end
            end
            if (c == 1 || c == 25 || c == 26) begin
                n_checks++;
                if ((c == 1 && ld_a !== 1'b1) || (c == 25 && (rn_a !== 1'b1 || ix_a !== 5'd23)) ||
                    (c == 26 && dn_a !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL nominal_latency cyc=%0d got ld=%b rn=%b idx=%0d dn=%b", c, ld_a, rn_a, ix_a, dn_a);
                end
            end
        end
        for (int c = 31; c <= 36; c++) begin
            step();
            if (c == 34) begin
                n_checks++;
                if (dn_b !== 1'b1 || ix_b !== 5'd0) begin
                    n_fail++;
                    $display("FAIL boundary32_done got dn=%b idx=%0d exp dn=1 idx=0", dn_b, ix_b);
                end
            end
            if (c == 33) begin
                n_checks++;
                if (rn_b !== 1'b1 || ix_b !== 5'd31) begin
                    n_fail++;
                    $display("FAIL boundary32_last got rn=%b idx=%0d exp rn=1 idx=31", rn_b, ix_b);
                end
            end
        end
        start_s = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs(i) !== expv(i) || obs(i) !== 9'd0) begin
                n_fail++;
                $display("FAIL done_release[%0d] got=%b exp=%b", i, obs(i), 9'd0);
            end
        end
        idle_out(2);
    endtask

    task automatic test_controller_loop();
        int loads = 0;
        int rounds = 0;
        start_s = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            loads  += int'(ld_a);
            rounds += int'(rn_a);
            if (dn_a) start_s = 1'b0;
        end
        n_checks++;
        if (loads != 1 || rounds != 24 || by_a !== 1'b0 || dn_a !== 1'b0) begin
            n_fail++;
            $display("FAIL controller_loop got loads=%0d rounds=%0d busy=%b done=%b exp 1/24/0/0", loads, rounds, by_a, dn_a);
        end
        idle_out(2);
    endtask

    task automatic test_abort();
        int c = 0;
        start_s = 1'b1;
        while (!(rn_a === 1'b1 && ix_a === 5'd10) && c < 40) begin
            step(); c++;
        end
        n_checks++;
        if (c >= 40) begin
            n_fail++;
            $display("FAIL abort_reach got idx=%0d exp idx=10 within 40 cycles", ix_a);
        end
        start_s = 1'b0;
        step();
        n_checks++;
        if (rn_a !== 1'b0 || ix_a !== 5'd0 || by_a !== 1'b0 || obs(0) !== expv(0)) begin
            n_fail++;
            $display("FAIL abort_next got rn=%b idx=%0d busy=%b exp 0/0/0", rn_a, ix_a, by_a);
        end
        for (int k = 0; k < 50; k++) begin
            step();
            n_checks++;
            if (dn_a !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done cyc=%0d got=%b exp=0", k, dn_a);
            end
        end
    endtask

    task automatic test_async_reset();
        int c = 0;
        start_s = 1'b1;
        while (!(rn_a === 1'b1 && ix_a === 5'd5) && c < 40) begin
            step(); c++;
        end
        #2 RST = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            ph[i] = -1; stl[i] = 1'b0;
            n_checks++;
            if (obs(i) !== 9'd0) begin
                n_fail++;
                $display("FAIL async_reset[%0d] got=%b exp=%b", i, obs(i), 9'd0);
            end
        end
        #2 RST = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL rerun[%0d] cyc=%0d got=%b exp=%b", i, k, obs(i), expv(i));
                end
            end
        end
        n_checks++;
        if (dn_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_done got=%b exp=1", dn_a);
        end
        idle_out(40);
    endtask

    task automatic test_back_to_back();
        for (int op = 0; op < 3; op++) begin
            start_s = 1'b1;
            for (int k = 0; k < 40; k++) begin
                step();
                for (int i = 0; i < 3; i++) begin
                    n_checks++;
                    if (obs(i) !== expv(i)) begin
                        n_fail++;
                        $display("FAIL back_to_back[%0d] op=%0d cyc=%0d got=%b exp=%b", i, op, k, obs(i), expv(i));
                    end
                end
            end
            start_s = 1'b0;
            step();
        end
        idle_out(2);
    endtask

`ifdef ROUND_STALL_EN
    task automatic test_stall();
        start_s = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            stall_s = (c >= 9 && c <= 11);
            if (c >= 10 && c <= 12) begin
                n_checks++;
                if (rn_a !== 1'b0 || ix_a !== 5'd7 || by_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d got rn=%b idx=%0d busy=%b exp 0/7/1", c, rn_a, ix_a, by_a);
                end
            end
            if (c == 28 || c == 29) begin
                n_checks++;
                if (dn_a !== (c == 29)) begin
                    n_fail++;
                    $display("FAIL stall_done cyc=%0d got=%b exp=%b", c, dn_a, (c == 29));
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL stall_model[%0d] cyc=%0d got=%b exp=%b", i, c, obs(i), expv(i));
                end
            end
        end
        idle_out(3);
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) start_s = ~start_s;
`ifdef ROUND_STALL_EN
            stall_s = ($urandom_range(0, 4) == 0);
`endif
            step();
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL random[%0d] cyc=%0d got=%b exp=%b", i, k, obs(i), expv(i));
                end
            end
        end
        idle_out(2);
    endtask

    initial begin
        nr[0] = 24; nr[1] = 32; nr[2] = 1;
        for (int i = 0; i < 3; i++) begin
            ph[i] = -1; stl[i] = 1'b0;
        end
        test_reset();
        test_nominal();
        test_controller_loop();
        test_abort();
        test_async_reset();
        test_back_to_back();
`ifdef ROUND_STALL_EN
        test_stall();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Sits directly downstream of the start/done state controller.
- Consumes its level-type State_start and drives the datapath of a permutation core: one load strobe, then NUM_ROUNDS round-enable cycles with a round index.
- Returns Done_flag to the controller to close the start/done handshake.
- Provides an abort path: the operation is cancelled if State_start drops before completion.

Parameters:
- NUM_ROUNDS, 24, number of round cycles per operation (legal range 1..2^RND_W).
- RND_W, 5, width of Round_idx.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all state immediately.
- State_start  input  1  level request from the start/done controller; high = run.
- Load_en  output  1  one-cycle strobe: datapath captures input block.
- Round_en  output  1  high during each round cycle.
- Round_idx  output  RND_W  current round number, 0..NUM_ROUNDS-1; 0 outside ROUND.
- Busy  output  1  high in LOAD and ROUND.
- Done_flag  output  1  completion flag to the controller.
- Stall  input  1  present only when ROUND_STALL_EN is defined (see Optional Feature).

Behaviour:
- All outputs are registered. Reset values: Load_en=0, Round_en=0, Round_idx=0, Busy=0, Done_flag=0; FSM=IDLE, round counter=0.
- FSM states and transitions:
  - IDLE: if State_start=1, go to LOAD next cycle. A request held high from reset also starts an operation; no edge is required.
  - LOAD: exactly one cycle with Load_en=1, Busy=1. Next state is ROUND with counter=0. If State_start=0 in this cycle, go to IDLE (abort).
  - ROUND: Round_en=1, Busy=1, Round_idx=counter. Each cycle the counter increments. When counter=NUM_ROUNDS-1, the next state is DONE. If State_start=0 in this cycle, go to IDLE (abort), with the counter cleared.
  - DONE: Done_flag=1, Busy=0, Round_en=0. Hold until State_start=0, then go to IDLE with Done_flag cleared. Done_flag stays high for at least one cycle even if State_start falls in the same cycle DONE is entered.
- Latency: the first State_start=1 sample gives Load_en one cycle later. Round 0 follows in the next cycle. Done_flag rises NUM_ROUNDS+2 cycles after the sampling edge.
- Round cycles are contiguous; Round_idx never skips, repeats or wraps within an operation.
- Counter is RND_W bits; the comparison against NUM_ROUNDS-1 is done at RND_W width. NUM_ROUNDS=2^RND_W is legal: the last index is all-ones and the counter never overflows.
- Abort from LOAD or ROUND: next cycle is IDLE with all outputs at reset values. Done_flag is never asserted for an aborted operation.
- Re-trigger: after DONE→IDLE, a new State_start=1 starts a fresh operation with counter=0. There is a minimum 1-cycle gap in IDLE between operations.
- Reset mid-operation: all outputs go to reset values asynchronously. Operation resumes only via a new State_start after RST is released.
- Only one of Load_en, Round_en, Done_flag is ever high in a given cycle.

Optional Feature:
- Macro: ROUND_STALL_EN.
- Defined:
  - Stall input port exists.
  - In ROUND with Stall=1: counter and Round_idx hold, Round_en=0, Busy stays 1.
  - Stall in LOAD or DONE is ignored.
  - Abort (State_start=0) takes priority over Stall.
  - Done latency grows by the number of stalled ROUND cycles.
- Undefined: no Stall port; rounds run back-to-back as above.

Test Plan:
- Nominal run (NUM_ROUNDS=24): reset, then State_start=1 at cycle 0.
  - Load_en=1 at cycle 1.
  - Round_en=1 at cycles 2..25 with Round_idx 0..23.
  - Done_flag=1 from cycle 26 until State_start=0, then 0 on the next cycle.
- Controller loop: connect to the start/done controller with Start_in held high. State_start falls after Done_flag, the sequencer returns to IDLE, and exactly one Load_en pulse and 24 Round_en pulses are seen.
- Abort: drop State_start while Round_idx=10. Next cycle Round_en=0, Round_idx=0, Busy=0; Done_flag stays 0 for 50 following cycles.
- Async reset mid-ROUND: assert RST between clock edges at Round_idx=5. All outputs are 0 before the next edge. After release with State_start=1, a full 24-round sequence runs from index 0.
- Boundary: NUM_ROUNDS=32, RND_W=5. Round_idx runs 0..31, Done_flag follows index 31, no wrap to 0 inside ROUND. NUM_ROUNDS=1 gives a single round, index 0.
- ROUND_STALL_EN: Stall=1 for 3 cycles at Round_idx=7. Round_idx holds at 7 and Round_en=0 for those cycles. Done_flag rises at cycle 29 instead of 26.
